// File: rtl/delay_pipe_op.sv
// Two-operand ALU whose result is delivered after a runtime-programmable latency.
// Supports flush, guarded latency reload, a busy flag and a saturating delivered-result count.
module delay_pipe_op #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_DELAY = 8,
  parameter int unsigned CNT_W     = 16,
  localparam int unsigned DW       = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op_sel,
  input  logic             cfg_load,
  input  logic [DW-1:0]    delay_cfg,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH:0]   c,
  output logic             busy,
  output logic             cfg_err,
  output logic [CNT_W-1:0] out_count
);

  localparam int unsigned RW = WIDTH + 1;

  typedef struct packed {
    logic          v;
    logic [RW-1:0] r;
  } stage_t;

  // Entry j is presented on the outputs after j+1 more edges; the top entry is never written.
  stage_t           pipe_q [MAX_DELAY];
  stage_t           pipe_d [MAX_DELAY];
  logic [DW-1:0]    d_q, d_d;
  logic             out_valid_q, out_valid_d;
  logic [RW-1:0]    c_q, c_d;
  logic             busy_q, busy_d;
  logic             cfg_err_q, cfg_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [RW-1:0]    res_c;
  logic             cfg_ok_c;
  logic             accept_c;
  logic             take_c;
  logic [DW-1:0]    d_eff_c;

  always_comb begin
    res_c = '0;
    unique case (op_sel)
      2'b00:   res_c = {1'b0, a} + {1'b0, b};
      2'b01:   res_c = {1'b0, a} - {1'b0, b};
      2'b10:   res_c = RW'(a == b);
      default: res_c = (a >= b) ? {1'b0, a} : {1'b0, b};
    endcase
  end

  // A new latency applies to an item sampled together with the load.
  always_comb begin
    cfg_ok_c = (delay_cfg != '0) && (32'(delay_cfg) <= MAX_DELAY);
    accept_c = cfg_load && cfg_ok_c && (!busy_q || flush);
    d_eff_c  = accept_c ? delay_cfg : d_q;
    take_c   = in_valid && !flush;
  end

  always_comb begin
    for (int j = 0; j < int'(MAX_DELAY) - 1; j++) begin
      pipe_d[j] = pipe_q[j+1];
    end
    pipe_d[MAX_DELAY-1] = '0;
    out_valid_d = pipe_q[0].v;
    c_d         = pipe_q[0].v ? pipe_q[0].r : c_q;
    d_d         = d_eff_c;
    cfg_err_d   = cfg_load && !accept_c;
    cnt_d       = (out_valid_q && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

    if (take_c) begin
      if (d_eff_c == DW'(1)) begin
        out_valid_d = 1'b1;
        c_d         = res_c;
      end else begin
        for (int j = 0; j < int'(MAX_DELAY) - 1; j++) begin
          if (int'(d_eff_c) == j + 2) begin
            pipe_d[j].v = 1'b1;
            pipe_d[j].r = res_c;
          end
        end
      end
    end

    if (flush) begin
      for (int j = 0; j < int'(MAX_DELAY); j++) begin
        pipe_d[j].v = 1'b0;
      end
      out_valid_d = 1'b0;
      c_d         = c_q;
    end

    busy_d = take_c;
    for (int j = 0; j < int'(MAX_DELAY); j++) begin
      busy_d = busy_d | pipe_d[j].v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < int'(MAX_DELAY); j++) begin
        pipe_q[j] <= '0;
      end
      d_q         <= DW'(1);
      out_valid_q <= 1'b0;
      c_q         <= '0;
      busy_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      for (int j = 0; j < int'(MAX_DELAY); j++) begin
        pipe_q[j] <= pipe_d[j];
      end
      d_q         <= d_d;
      out_valid_q <= out_valid_d;
      c_q         <= c_d;
      busy_q      <= busy_d;
      cfg_err_q   <= cfg_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign c         = c_q;
  assign busy      = busy_q;
  assign cfg_err   = cfg_err_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_delay_pipe_op.sv
// Scoreboard bench for delay_pipe_op: stimulus queues expected results by due cycle,
// a negedge monitor compares out_valid/c every cycle.
module tb_delay_pipe_op;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned MAX_DELAY = 8;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned DW        = $clog2(MAX_DELAY + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [1:0]       op_sel = 2'b00;
  logic             cfg_load = 1'b0;
  logic [DW-1:0]    delay_cfg = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic [WIDTH:0]   c;
  logic             busy;
  logic             cfg_err;
  logic [CNT_W-1:0] out_count;

  typedef struct {
    int             due;
    logic [WIDTH:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   tb_d = 1;
  bit   mon_ev;

  delay_pipe_op #(.WIDTH(WIDTH), .MAX_DELAY(MAX_DELAY), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .op_sel(op_sel),
    .cfg_load(cfg_load), .delay_cfg(delay_cfg), .flush(flush),
    .out_valid(out_valid), .c(c), .busy(busy), .cfg_err(cfg_err), .out_count(out_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [1:0] op,
                       input logic [8:0] ex, input bit track);
    exp_t e;
    in_valid = 1'b1;
    a        = ia;
    b        = ib;
    op_sel   = op;
    if (track) begin
      e.due = cyc + tb_d;
      e.val = ex;
      exp_q.push_back(e);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic cfg(input int v, input bit exp_err);
    cfg_load  = 1'b1;
    delay_cfg = DW'(v);
    tick();
    cfg_load = 1'b0;
    check("cfg_err", 32'(cfg_err), 32'(exp_err));
    if (!exp_err) tb_d = v;
  endtask

  // Per-cycle output check against the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      mon_ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      check("out_valid", 32'(out_valid), 32'(mon_ev));
      if (mon_ev) begin
        check("c", 32'(c), 32'(exp_q[0].val));
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #1;
    check("rst out_valid", 32'(out_valid), 0);
    check("rst c", 32'(c), 0);
    check("rst busy", 32'(busy), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Reset mid-stream discards in-flight items and zeroes outputs at once.
    cfg(4, 1'b0);
    issue(8'd1, 8'd2, 2'b00, 9'd3, 1'b1);
    issue(8'd3, 8'd4, 2'b00, 9'd7, 1'b1);
    issue(8'd5, 8'd6, 2'b00, 9'd11, 1'b1);
    rst_n = 1'b0;
    exp_q.delete();
    tb_d = 1;
    #1;
    check("rst2 out_valid", 32'(out_valid), 0);
    check("rst2 c", 32'(c), 0);
    check("rst2 busy", 32'(busy), 0);
    check("rst2 cfg_err", 32'(cfg_err), 0);
    check("rst2 out_count", 32'(out_count), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    issue(8'd1, 8'd1, 2'b00, 9'd2, 1'b1);
    repeat (3) tick();

    // D=1 add with carry.
    issue(8'd200, 8'd100, 2'b00, 9'h12C, 1'b1);
    repeat (3) tick();
    check("out_count d1", 32'(out_count), 2);

    // Latency 4, mixed ops, back-to-back.
    cfg(4, 1'b0);
    issue(8'd5, 8'd3, 2'b01, 9'd2, 1'b1);
    check("busy n+1", 32'(busy), 1);
    issue(8'd1, 8'd2, 2'b01, 9'h1FF, 1'b1);
    check("busy n+2", 32'(busy), 1);
    issue(8'd7, 8'd7, 2'b10, 9'd1, 1'b1);
    check("busy n+3", 32'(busy), 1);
    issue(8'd4, 8'd9, 2'b11, 9'd9, 1'b1);
    check("busy n+4", 32'(busy), 1);
    tick();
    check("busy n+5", 32'(busy), 1);
    tick();
    check("busy n+6", 32'(busy), 1);
    tick();
    check("busy n+7", 32'(busy), 0);
    repeat (3) tick();

    // Reload while busy is rejected; item keeps latency 4.
    issue(8'd10, 8'd20, 2'b00, 9'd30, 1'b1);
    cfg(2, 1'b1);
    tick();
    check("cfg_err one cycle", 32'(cfg_err), 0);
    repeat (5) tick();
    cfg(0, 1'b1);
    cfg(9, 1'b1);
    tick();
    check("cfg_err clear", 32'(cfg_err), 0);
    issue(8'd3, 8'd4, 2'b00, 9'd7, 1'b1);
    repeat (6) tick();

    // Flush with a new item at D=6: nothing emerges.
    cfg(6, 1'b0);
    issue(8'd1, 8'd1, 2'b00, 9'd2, 1'b0);
    issue(8'd2, 8'd2, 2'b00, 9'd4, 1'b0);
    issue(8'd3, 8'd3, 2'b00, 9'd6, 1'b0);
    flush = 1'b1;
    issue(8'd4, 8'd4, 2'b00, 9'd8, 1'b0);
    flush = 1'b0;
    check("flush busy", 32'(busy), 0);
    check("flush out_valid", 32'(out_valid), 0);
    repeat (8) tick();

    // Flush together with a reload is accepted.
    issue(8'd1, 8'd1, 2'b00, 9'd2, 1'b0);
    issue(8'd2, 8'd2, 2'b00, 9'd4, 1'b0);
    flush = 1'b1;
    cfg(2, 1'b0);
    flush = 1'b0;
    check("flush+cfg busy", 32'(busy), 0);
    issue(8'd9, 8'd4, 2'b01, 9'd5, 1'b1);
    repeat (4) tick();

    check("final out_count", 32'(out_count), 9);
    check("scoreboard empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
